// File: rtl/left_shift_deser.sv
// left_shift_deser: MSB-first serial-to-parallel receiver.
// DW strobed bits are assembled into a word, which is then handed to the
// consumer through a one-entry valid/ready holding register.
// A word that completes while the holding register is still full is
// dropped, and the sticky overrun flag records the loss.
module left_shift_deser #(
  parameter  int DW = 4,
  localparam int CW = (DW > 2) ? $clog2(DW) : 1
) (
  input  logic          clk,
  input  logic          async_rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic          din,
  output logic [DW-1:0] shift_q,
  output logic [CW-1:0] cnt,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          overrun
);

  // The holding register's occupancy is the whole output state machine.
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } holdState_e;

  holdState_e    state_q, state_d;
  logic [DW-1:0] shiftReg_q, shiftReg_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] word_q, word_d;
  logic          overrunFlag_q, overrunFlag_d;

  logic          takeBit;
  logic          lastBit;
  logic          wordDone;
  logic [DW-1:0] newWord;

  // Decode whether this edge takes a bit, and whether that bit finishes a word.
  // clr wins over en, so a clear cycle never consumes din.
  always_comb begin
    takeBit  = en && !clr;
    lastBit  = (count_q == CW'(DW - 1));
    wordDone = takeBit && lastBit;
    newWord  = {shiftReg_q[DW-2:0], din};
  end

  // Next state of the shifter and bit counter.
  // The counter wraps only when a word completes.
  always_comb begin
    shiftReg_d = shiftReg_q;
    count_d    = count_q;
    if (clr) begin
      shiftReg_d = '0;
      count_d    = '0;
    end else if (takeBit) begin
      shiftReg_d = newWord;
      count_d    = lastBit ? '0 : count_q + CW'(1);
    end
  end

  // Holding register handshake and overrun detection.
  // Accept and refill on the same edge keeps dout_valid high with no bubble.
  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    overrunFlag_d = overrunFlag_q;
    unique case (state_q)
      EMPTY: begin
        if (wordDone) begin
          word_d  = newWord;
          state_d = FULL;
        end
      end
      FULL: begin
        if (wordDone) begin
          if (dout_ready) begin
            word_d = newWord;
          end else begin
            overrunFlag_d = 1'b1;
          end
        end else if (dout_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (clr) begin
      overrunFlag_d = 1'b0;
    end
  end

  // State registers; reset clears everything immediately, without a clock.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q       <= EMPTY;
      shiftReg_q    <= '0;
      count_q       <= '0;
      word_q        <= '0;
      overrunFlag_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shiftReg_q    <= shiftReg_d;
      count_q       <= count_d;
      word_q        <= word_d;
      overrunFlag_q <= overrunFlag_d;
    end
  end

  // Every output comes straight from a register.
  always_comb begin
    shift_q    = shiftReg_q;
    cnt        = count_q;
    dout       = word_q;
    dout_valid = (state_q == FULL);
    overrun    = overrunFlag_q;
  end

endmodule
